bcd_seq_converter: RTL and testbench
====================================

BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 SHALL have parameter IN_W, default 13, meaning binary input width; legal range 1..13.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  conversion request, sampled on rising clk edge.
REQ-005 SHALL have port num  input  IN_W  unsigned binary value to convert.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  single-cycle pulse marking new digit values.
REQ-008 SHALL have ports Thousands, Hundreds, Tens, Ones  output  4 each  registered BCD digits, directly feeding the 4-digit seven-segment driver.

Function
REQ-009 SHALL implement a sequential shift-and-add-3 (double-dabble) converter, one input bit per clock.
REQ-010 SHALL use FSM states IDLE, SHIFT, FINISH; IDLE->SHIFT on accepted start; SHIFT->FINISH after IN_W shift cycles; FINISH->IDLE or FINISH->SHIFT unconditionally after one cycle.
REQ-011 SHALL accept start only when busy=0 (IDLE or FINISH); on acceptance, latch num into an internal shift register and clear the 16-bit BCD scratch register.
REQ-012 SHALL, in each SHIFT cycle, add 3 to every scratch nibble >=5, then shift {scratch, shift register} left by one bit.
REQ-013 SHALL drive busy=1 in every SHIFT cycle and busy=0 in IDLE and FINISH.
REQ-014 SHALL load the four digit outputs from the scratch register and assert done for exactly one cycle in FINISH; latency from the start-accepting edge to done high is IN_W+1 cycles (14 for IN_W=13).
REQ-015 SHALL hold digit outputs stable at the last completed result at all other times; intermediate scratch values SHALL never appear on outputs.
REQ-016 SHALL ignore start and changes on num while busy=1; the in-flight conversion uses the value latched at acceptance.
REQ-017 SHALL accept start asserted in the FINISH cycle, giving back-to-back conversions with period IN_W+1 cycles.
REQ-018 SHALL produce Thousands<=8 for any input; digits SHALL always be valid BCD (0..9).
REQ-019 SHALL convert 0 to 0000 and 8191 to 8191 (boundary values).

Reset
REQ-020 SHALL, on rst high, asynchronously force state IDLE, busy=0, done=0, all four digits 0, scratch and shift registers 0.
REQ-021 SHALL abort any in-flight conversion on rst without asserting done; digits remain 0 until the next completed conversion.
REQ-022 SHALL not accept start in the first rising edge at which rst is still high; first acceptance is the first edge with rst low.

Configuration
REQ-023 SHALL support macro BCD_SEQ_AUTO_CONVERT_EN.
REQ-024 With BCD_SEQ_AUTO_CONVERT_EN defined: SHALL hold a register of the last accepted num and internally generate a request whenever busy=0 and num differs from it (OR-ed with start); after reset the register SHALL hold 0, so a nonzero num triggers one conversion.
REQ-025 Without BCD_SEQ_AUTO_CONVERT_EN: conversions SHALL start only on external start; no last-value register is implemented.

Verification
REQ-026 Reset then start with num=1234 -> busy high 13 cycles, done one cycle 14 cycles after start edge, digits 1,2,3,4.
REQ-027 Boundaries: num=0 -> 0,0,0,0; num=8191 -> 8,1,9,1; num=9 -> 0,0,0,9; num=1000 -> 1,0,0,0.
REQ-028 start with num=4321, change num to 7777 and pulse start at cycle 5 -> result 4,3,2,1; no second done until a new start is accepted.
REQ-029 start held high continuously with num=55 -> done every 14 cycles, digits 0,0,5,5; outputs never glitch between pulses.
REQ-030 rst asserted mid-conversion (cycle 7) for num=999 -> no done, digits 0,0,0,0, busy 0 immediately; next start converts correctly.
REQ-031 With BCD_SEQ_AUTO_CONVERT_EN, start tied low: num steps 0->42->42->8000 -> exactly two done pulses, digits 0,0,4,2 then 8,0,0,0.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Optional BCD_SEQ_AUTO_CONVERT_EN: self-triggers a conversion whenever num changes while idle.
module bcd_seq_converter #(
  parameter int unsigned IN_W = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] num,
  output logic            busy,
  output logic            done,
  output logic [3:0]      Thousands,
  output logic [3:0]      Hundreds,
  output logic [3:0]      Tens,
  output logic [3:0]      Ones
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned CAT_W = BCD_W + IN_W;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t            state;
  logic [BCD_W-1:0]  scratch;
  logic [IN_W-1:0]   shift_reg;
  logic [CNT_W-1:0]  cnt;
  logic              req_c;
  logic              accept_c;
  logic [CAT_W-1:0]  shifted_c;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_SEQ_AUTO_CONVERT_EN
  logic [IN_W-1:0] last_num;
  assign req_c = start | (num != last_num);
`else
  assign req_c = start;
`endif

  // A request is only taken when not shifting, which also lets FINISH chain into a new conversion.
  assign accept_c = req_c && (state != SHIFT);

  always_comb begin
    shifted_c = {add3(scratch), shift_reg} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      scratch   <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      Thousands <= 4'd0;
      Hundreds  <= 4'd0;
      Tens      <= 4'd0;
      Ones      <= 4'd0;
`ifdef BCD_SEQ_AUTO_CONVERT_EN
      last_num  <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BCD_SEQ_AUTO_CONVERT_EN
      if (accept_c) last_num <= num;
`endif
      case (state)
        IDLE: begin
          if (accept_c) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            scratch   <= '0;
            shift_reg <= num;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          scratch   <= shifted_c[IN_W +: BCD_W];
          shift_reg <= shifted_c[IN_W-1:0];
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FINISH;
            busy  <= 1'b0;
          end
        end
        FINISH: begin
          // Digits change only here, so partial scratch values never reach the display.
          Thousands <= scratch[15:12];
          Hundreds  <= scratch[11:8];
          Tens      <= scratch[7:4];
          Ones      <= scratch[3:0];
          done      <= 1'b1;
          if (accept_c) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            scratch   <= '0;
            shift_reg <= num;
            cnt       <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter (IN_W=13).
module tb_bcd_seq_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] num;
  logic        busy;
  logic        done;
  logic [3:0]  Thousands, Hundreds, Tens, Ones;

  int total = 0;
  int bad   = 0;

  bcd_seq_converter #(.IN_W(13)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num),
    .busy(busy), .done(done),
    .Thousands(Thousands), .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] n;
    logic [15:0] bcd;
  } vec_t;

  function automatic logic [15:0] digits();
    return {Thousands, Hundreds, Tens, Ones};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_conv(input logic [12:0] n, input logic [15:0] exp_bcd);
    int lat;
    int busy_cnt;
    num   = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    chk($sformatf("latency_%0d", n), lat, 14);
    chk($sformatf("busy_cycles_%0d", n), busy_cnt, 13);
    chk($sformatf("digits_%0d", n), int'(digits()), int'(exp_bcd));
    tick();
    chk($sformatf("done_width_%0d", n), int'(done), 0);
  endtask

  vec_t vecs[12];

  initial begin
    int ndone;
    int prev;
    int first;
    int glitch;
    int lat;

    vecs[0]  = '{13'd1234, 16'h1234};
    vecs[1]  = '{13'd0,    16'h0000};
    vecs[2]  = '{13'd8191, 16'h8191};
    vecs[3]  = '{13'd9,    16'h0009};
    vecs[4]  = '{13'd1000, 16'h1000};
    vecs[5]  = '{13'd55,   16'h0055};
    vecs[6]  = '{13'd4321, 16'h4321};
    vecs[7]  = '{13'd999,  16'h0999};
    vecs[8]  = '{13'd5,    16'h0005};
    vecs[9]  = '{13'd10,   16'h0010};
    vecs[10] = '{13'd4095, 16'h4095};
    vecs[11] = '{13'd7999, 16'h7999};

    rst   = 1'b1;
    start = 1'b0;
    num   = '0;
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_digits", int'(digits()), 0);

    // start while reset is still high must be ignored
    start = 1'b1;
    num   = 13'd1234;
    tick();
    chk("start_in_reset_busy", int'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_after_reset_busy", int'(busy), 0);

`ifdef BCD_SEQ_AUTO_CONVERT_EN
    ndone = 0;
    num = 13'd0;
    for (int k = 0; k < 20; k++) begin tick(); if (done) ndone++; end
    chk("auto_zero_no_conv", ndone, 0);
    num = 13'd42;
    for (int k = 0; k < 30; k++) begin tick(); if (done) ndone++; end
    chk("auto_42_digits", int'(digits()), 16'h0042);
    for (int k = 0; k < 30; k++) begin tick(); if (done) ndone++; end
    chk("auto_42_once", ndone, 1);
    num = 13'd8000;
    for (int k = 0; k < 30; k++) begin tick(); if (done) ndone++; end
    chk("auto_8000_digits", int'(digits()), 16'h8000);
    chk("auto_done_count", ndone, 2);
`else
    for (int i = 0; i < 12; i++) run_conv(vecs[i].n, vecs[i].bcd);

    // num and start change mid-conversion: in-flight value wins, no extra conversion
    num   = 13'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    num   = 13'd7777;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 6; k <= 40; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    chk("ignore_latency", lat, 14);
    chk("ignore_digits", int'(digits()), 16'h4321);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin tick(); if (done) ndone++; end
    chk("ignore_no_second_done", ndone, 0);
    chk("ignore_digits_hold", int'(digits()), 16'h4321);

    // start held high: back-to-back conversions every 14 cycles
    num   = 13'd55;
    start = 1'b1;
    tick();
    ndone = 0; prev = -1; first = -1; glitch = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (done) begin
        ndone++;
        if (prev >= 0) chk("b2b_gap", k - prev, 14);
        else first = k;
        prev = k;
      end
      if (first >= 0 && digits() != 16'h0055) glitch++;
    end
    start = 1'b0;
    chk("b2b_first", first, 14);
    chk("b2b_count", ndone, 5);
    chk("b2b_glitch", glitch, 0);
    repeat (20) tick();

    // reset mid-conversion aborts without done
    num   = 13'd999;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_digits", int'(digits()), 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (done) ndone++; end
    chk("abort_no_done", ndone, 0);
    chk("abort_digits_hold", int'(digits()), 0);
    run_conv(13'd999, 16'h0999);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
